// File: rtl/apb_pkg.sv
// Shared APB definitions for the completer side of the bus.
//   - apb_state_e : completer FSM state (IDLE, ACCESS)
//   - APB_ADDR_W / APB_DATA_W : default in-region address and data widths
//   - ERR_* : latched error reasons; any non-zero reason raises PSLVERR on completion
//   - cnt_width() : wait-state counter width, never narrower than one bit
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_PROT  = 2'b10;

  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Byte register file behind the APB completer.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset (clears every byte and rd_data)
//   wr_en/addr/data    : synchronous write port
//   rd_en/addr/zero    : registered read; rd_zero forces the captured value to 0
//   rd_data            : registered read data, holds between reads
module apb_slv_regfile #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Out-of-range reads never index the array: rd_zero masks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_zero ? '0 : mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer backed by a byte register file, with programmable wait states.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   PSEL, PENABLE   : APB select / access-phase strobe
//   PWRITE, PADDR,
//   PWDATA          : transfer attributes, sampled only in the setup phase
//   PREADY          : high for the completion cycle of the access phase
//   PRDATA          : read data, registered at setup, holds between transfers
//   PSLVERR         : error response, only ever high together with PREADY
// Build option: define APB_MEM_SLAVE_WRITE_PROT_EN to make RO_BASE..DEPTH-1 read-only;
// writes there complete with PSLVERR and leave memory untouched.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RO_BASE     = 224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int unsigned     CntW    = cnt_width(WAIT_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES);

  if (DEPTH == 0 || DEPTH > 2**ADDR_W || RO_BASE > 2**ADDR_W) begin : g_bad_cfg
    $error("apb_mem_slave: DEPTH/RO_BASE outside the address space");
  end

  apb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        err_rsn;
  logic              setup;
  logic              rd_en;
  logic              mem_we;

  // Error reason for the transfer presented in the setup phase.
  always_comb begin
    err_rsn = ERR_NONE;
    if (32'(PADDR) >= DEPTH) begin
      err_rsn = ERR_RANGE;
    end
`ifdef APB_MEM_SLAVE_WRITE_PROT_EN
    else if (PWRITE && 32'(PADDR) >= RO_BASE) begin
      err_rsn = ERR_PROT;
    end
`endif
  end

  assign setup = PSEL && !PENABLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // PENABLE without a preceding setup phase is ignored.
        if (setup) begin
          wr_d    = PWRITE;
          addr_d  = PADDR;
          wdata_d = PWDATA;
          err_d   = err_rsn;
          cnt_d   = CntLoad;
          rd_en   = !PWRITE;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Aborted transfer: nothing is committed.
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else begin
            mem_we  = wr_q && (err_q == ERR_NONE);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
  assign PSLVERR = PREADY && (err_q != ERR_NONE);

  apb_slv_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (addr_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_zero (err_rsn == ERR_RANGE),
    .rd_addr (PADDR),
    .rd_data (PRDATA)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: two instances share the APB bus signals
// (A: 256 bytes, 2 wait states; B: 200 bytes, zero-wait) and are checked against
// a plain byte-array model of each memory.
module tb_apb_mem_slave;

  localparam int unsigned DEPTH_A = 256;
  localparam int unsigned WAIT_A  = 2;
  localparam int unsigned DEPTH_B = 200;
  localparam int unsigned WAIT_B  = 0;
  localparam int unsigned RO_BASE = 224;
`ifdef APB_MEM_SLAVE_WRITE_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       psel_a, psel_b, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready_a, pready_b, pslverr_a, pslverr_b;
  logic [7:0] prdata_a, prdata_b;

  always #5 clk = ~clk;

  apb_mem_slave #(
    .DEPTH       (DEPTH_A),
    .WAIT_CYCLES (WAIT_A),
    .RO_BASE     (RO_BASE)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .PSEL    (psel_a),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PREADY  (pready_a),
    .PRDATA  (prdata_a),
    .PSLVERR (pslverr_a)
  );

  apb_mem_slave #(
    .DEPTH       (DEPTH_B),
    .WAIT_CYCLES (WAIT_B),
    .RO_BASE     (RO_BASE)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .PSEL    (psel_b),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PREADY  (pready_b),
    .PRDATA  (prdata_b),
    .PSLVERR (pslverr_b)
  );

  // Reference model
  logic [7:0]  mem_m   [2][256];
  logic [7:0]  last_rd [2];
  int unsigned depth_m [2] = '{DEPTH_A, DEPTH_B};
  int unsigned wait_m  [2] = '{WAIT_A, WAIT_B};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic ready_of(input int t);
    return (t == 0) ? pready_a : pready_b;
  endfunction

  function automatic logic slverr_of(input int t);
    return (t == 0) ? pslverr_a : pslverr_b;
  endfunction

  function automatic logic [7:0] rdata_of(input int t);
    return (t == 0) ? prdata_a : prdata_b;
  endfunction

  function automatic bit exp_err(input int t, input bit wr, input logic [7:0] a);
    if (int'(a) >= int'(depth_m[t])) return 1'b1;
    if (PROT_EN && wr && int'(a) >= int'(RO_BASE)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      last_rd[t] = 8'h00;
      for (int i = 0; i < 256; i++) mem_m[t][i] = 8'h00;
    end
  endtask

  task automatic bus_idle();
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  // Full transfer; called at a falling edge, returns at a falling edge with the bus idle
  // so a following call issues its setup phase with no gap.
  task automatic xfer(input int t, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input bit jitter);
    int         waits;
    bit         e;
    logic [7:0] exp_rd;
    e       = exp_err(t, wr, a);
    psel_a  = (t == 0);
    psel_b  = (t == 1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(negedge clk);
    penable = 1'b1;
    waits   = 0;
    while (!ready_of(t) && waits <= 20) begin
      check("slverr_without_ready", slverr_of(t), 1'b0);
      if (jitter) paddr = 8'($urandom);
      @(negedge clk);
      waits++;
    end
    check("ready_latency", waits, wait_m[t]);
    if (ready_of(t)) begin
      check("pslverr", slverr_of(t), e);
      if (!wr) begin
        exp_rd     = e ? 8'h00 : mem_m[t][a];
        last_rd[t] = exp_rd;
      end
      check(wr ? "prdata_hold_on_write" : "prdata", rdata_of(t), last_rd[t]);
      if (wr && !e) mem_m[t][a] = d;
    end
    @(negedge clk);
    check("ready_after_done", ready_of(t), 1'b0);
    bus_idle();
  endtask

  // PSEL withdrawn during a wait state of instance A.
  task automatic abort_write(input logic [7:0] a, input logic [7:0] d);
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    @(negedge clk);
    penable = 1'b1;
    check("abort_wait_ready", pready_a, 1'b0);
    @(negedge clk);
    bus_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_ready", pready_a, 1'b0);
      check("abort_no_slverr", pslverr_a, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    pwrite = 1'b0;
    paddr  = 8'h00;
    pwdata = 8'h00;
    bus_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pready_a", pready_a, 1'b0);
    check("rst_pready_b", pready_b, 1'b0);
    check("rst_prdata_a", prdata_a, 8'h00);
    check("rst_prdata_b", prdata_b, 8'h00);
    check("rst_pslverr_a", pslverr_a, 1'b0);
    check("rst_pslverr_b", pslverr_b, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Wait-state write/read
    xfer(0, 1'b1, 8'h10, 8'hA5, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0);

    // Zero-wait, back-to-back
    xfer(1, 1'b1, 8'h01, 8'h3C, 1'b0);
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0);

    // Out-of-range on the 200-byte instance
    xfer(1, 1'b1, 8'hC7, 8'h00, 1'b0);
    xfer(1, 1'b1, 8'hC8, 8'h77, 1'b0);
    xfer(1, 1'b0, 8'hC8, 8'h00, 1'b0);
    xfer(1, 1'b0, 8'hC7, 8'h00, 1'b0);

    // Abort, then read back untouched location
    abort_write(8'h30, 8'h11);
    xfer(0, 1'b0, 8'h30, 8'h00, 1'b0);

    // PENABLE in IDLE without a setup phase must not start a transfer
    psel_b  = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h05;
    pwdata  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("enable_in_idle_ready", pready_b, 1'b0);
    end
    bus_idle();
    @(negedge clk);
    xfer(1, 1'b0, 8'h05, 8'h00, 1'b0);

    // Write-protected region (behaviour depends on the build option)
    xfer(0, 1'b1, 8'hE0, 8'h55, 1'b0);
    xfer(0, 1'b0, 8'hE0, 8'h00, 1'b0);
    xfer(0, 1'b1, 8'hDF, 8'h55, 1'b0);
    xfer(0, 1'b0, 8'hDF, 8'h00, 1'b0);

    // Reset in the middle of an access phase
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h20;
    pwdata  = 8'hFF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_pready", pready_a, 1'b0);
    check("midrst_pslverr", pslverr_a, 1'b0);
    check("midrst_prdata_a", prdata_a, 8'h00);
    check("midrst_prdata_b", prdata_b, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    model_reset();
    @(negedge clk);
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0);
    xfer(0, 1'b1, 8'h20, 8'h12, 1'b0);
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0);
    xfer(0, 1'b0, 8'hDF, 8'h00, 1'b0);

    // Randomized traffic, mostly on a small hot address set to hit read-after-write
    for (int n = 0; n < 300; n++) begin
      int         t;
      bit         wr;
      logic [7:0] a;
      t  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15)) | 8'hC0;
      else                           a = 8'($urandom);
      xfer(t, wr, a, 8'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB completer sitting directly downstream of the team's APB master: one instance per PSEL line (PSEL1 / PSEL2 region).
- Decodes the 8-bit in-region address into an on-chip byte register file.
- Drives PREADY with a programmable wait-state count and returns PRDATA / PSLVERR.
- Gives the master's ENABLE-state wait loop and error path a real, cycle-accurate partner.

Parameters:
- ADDR_W, 8, in-region address width (PADDR[7:0]; bit 8 is consumed by the master's PSEL decode)
- DATA_W, 8, data width
- DEPTH, 256, implemented byte locations; valid addresses are 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
- WAIT_CYCLES, 2, PREADY-low cycles inserted in the access phase (0 = zero-wait)
- RO_BASE, 224, first write-protected address; used only when the optional feature is compiled in

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- PSEL  in  1  select for this completer
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PREADY  out  1  transfer complete this cycle
- PRDATA  out  DATA_W  read data, valid when PREADY=1 and PWRITE=0
- PSLVERR  out  1  error response, valid only when PREADY=1

Behaviour:
- Reset (async assert, sync release): FSM to IDLE, wait counter 0, PREADY=0, PRDATA=0, PSLVERR=0, all memory bytes cleared to 0.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0 (setup phase), at the clock edge:
    - latch PWRITE, PADDR, PWDATA
    - latch err = (PADDR >= DEPTH)
    - load counter = WAIT_CYCLES
    - for reads, register PRDATA <= mem[PADDR] (0 if err)
    - go to ACCESS
  - ACCESS: PREADY = (counter == 0), a Moore output decoded from registered state only.
    - While counter != 0 and PSEL=PENABLE=1: decrement.
    - When counter == 0 and PSEL=PENABLE=1: completion cycle. At the edge, a write with no err commits mem[addr] <= wdata. Return to IDLE.
    - If PSEL drops in ACCESS (protocol abort): return to IDLE, no write, PREADY=0, PSLVERR=0.
- Latency: PREADY is first high in access-phase cycle WAIT_CYCLES+1. Total transfer = WAIT_CYCLES+2 cycles including setup.
- PSLVERR = err & PREADY. It is never high when PREADY=0.
  - An erroring write leaves memory unchanged.
  - An erroring read returns PRDATA=0.
- Back-to-back: the cycle after completion is IDLE. A setup phase seen in that cycle is accepted with no bubble.
- PRDATA holds its last value between transfers. Writes do not update PRDATA.
- PENABLE=1 seen in IDLE (no preceding setup) is ignored; stays in IDLE.
- Address latched at setup is used throughout. PADDR changes during ACCESS are ignored.
- Counter width = max(1, $clog2(WAIT_CYCLES+1)). It never wraps; it saturates at 0.
- Reset asserted mid-transfer aborts immediately: PREADY=0 and no partial write.

Optional Feature:
- Macro APB_MEM_SLAVE_WRITE_PROT_EN.
  - Defined: addresses RO_BASE..DEPTH-1 are read-only. A write to them completes normally (same wait states) with PSLVERR=1 and no memory update. Reads there are unaffected.
  - Undefined: RO_BASE is ignored and the whole array is writable. Behaviour is as above with no extra logic.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, ACCESS}
  - APB_ADDR_W=8, APB_DATA_W=8 constants
  - err-reason localparams (ERR_RANGE, ERR_PROT) for bench coverage
- One natural sub-module: apb_slv_regfile. It holds the DEPTH x DATA_W array with synchronous write, registered read port and reset clear.
- FSM, counter and error decode stay in apb_mem_slave.

Test Plan:
- WAIT_CYCLES=2, write addr 0x10 data 0xA5, then read 0x10 -> PREADY high in 3rd access cycle each time, PSLVERR=0, PRDATA=0xA5.
- WAIT_CYCLES=0, back-to-back write 0x01=0x3C then read 0x01 -> PREADY high in first access cycle, no idle bubble, PRDATA=0x3C.
- DEPTH=200, write 0xC8=0x77 then read 0xC8 -> PSLVERR=1 with PREADY both times, PRDATA=0, location 0xC7 unchanged.
- Assert rst during ACCESS of write 0x20=0xFF -> PREADY=0, PRDATA=0, mem[0x20]=0 after release. A new transfer then completes normally.
- PSEL dropped during a wait state of write 0x30=0x11 -> FSM back to IDLE, no PREADY pulse, a subsequent read of 0x30 returns 0x00.
- With APB_MEM_SLAVE_WRITE_PROT_EN, write 0xE0=0x55 -> PSLVERR=1, read 0xE0 returns 0x00. Write 0xDF=0x55 -> OK, reads back 0x55.
